// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cla_pkg
// Brief   : Shared constants and state encoding for the sequential CLA adder.
// Revision: 1.0 - initial release
// ============================================================================
package cla_pkg;

  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cla_carry4.sv
`default_nettype none
// ============================================================================
// Module  : cla_carry4
// Brief   : Combinational 4-bit two-level lookahead carry unit.
// Revision: 1.0 - initial release
// ============================================================================
module cla_carry4
  import cla_pkg::*;
(
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [4:1] c
);

  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

endmodule
`default_nettype wire

// File: rtl/cla_seq_adder.sv
`default_nettype none
// ============================================================================
// Module  : cla_seq_adder
// Brief   : Multi-cycle adder, one 4-bit lookahead slice per clock, with
//           valid/ready handshakes on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] c_last = IDXW'(N - 1);

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_creg;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g;
  logic [4:1]       w_c;
  logic [SLICE-1:0] w_s;

  // Single lookahead unit shared by all slices via the idx-selected operand mux
  assign w_a_sl = r_a[r_idx*SLICE +: SLICE];
  assign w_b_sl = r_b[r_idx*SLICE +: SLICE];
  assign w_p    = w_a_sl ^ w_b_sl;
  assign w_g    = w_a_sl & w_b_sl;
  assign w_s    = w_p ^ {w_c[3], w_c[2], w_c[1], r_creg};

  cla_carry4 u_carry4 (
    .g  (w_g),
    .p  (w_p),
    .ci (r_creg),
    .c  (w_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_creg      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_creg     <= cin;
            r_idx      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
          end
        end
        RUN: begin
          r_sum[r_idx*SLICE +: SLICE] <= w_s;
          r_creg <= w_c[4];
          if (r_idx == c_last) begin
            r_cout      <= w_c[4];
            r_ovf       <= w_c[3] ^ w_c[4];
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire
